// File: rtl/traffic_light_pkg.sv
// rtl/traffic_light_pkg.sv - shared phase encodings, fault codes and lamp helpers
//
// Purpose: types and helpers shared by the traffic light monitor and the
// intersection controller.
//   phase_e        : 2-bit phase encoding (00 G1R2, 01 Y1R2, 10 R1G2, 11 R1Y2)
//   FC_*           : 3-bit fault cause codes
//   lamps_t        : 6-bit lamp pattern {red1, yellow1, green1, red2, yellow2, green2}
//   next_phase     : the only legal successor of a phase
//   expected_dwell : nominal dwell of a phase in clk cycles

package traffic_light_pkg;

   typedef enum logic [1:0] {
      PH_G1R2 = 2'b00,
      PH_Y1R2 = 2'b01,
      PH_R1G2 = 2'b10,
      PH_R1Y2 = 2'b11
   } phase_e;

   localparam logic [2:0] FC_NONE      = 3'd0;
   localparam logic [2:0] FC_MALFORMED = 3'd1;
   localparam logic [2:0] FC_CONFLICT  = 3'd2;
   localparam logic [2:0] FC_SEQUENCE  = 3'd3;
   localparam logic [2:0] FC_SHORT     = 3'd4;
   localparam logic [2:0] FC_LONG      = 3'd5;

   typedef logic [5:0] lamps_t;

   // The phase cycle is a plain 2-bit increment with wrap.
   function automatic phase_e next_phase(input phase_e ph);
      return phase_e'(ph + 2'd1);
   endfunction

   function automatic logic [31:0] expected_dwell(input phase_e ph,
                                                  input logic [31:0] green_cycles,
                                                  input logic [31:0] yellow_cycles);
      if (ph == PH_Y1R2 || ph == PH_R1Y2) begin
         return yellow_cycles;
      end
      return green_cycles;
   endfunction

endpackage

// File: rtl/tlm_pattern_decode.sv
// rtl/tlm_pattern_decode.sv - combinational lamp pattern classifier
//
// Purpose: classifies one 6-bit lamp pattern.
//   lamps     in  6 : {red1, yellow1, green1, red2, yellow2, green2}
//   phase     out 2 : decoded phase, meaningful only when legal
//   legal     out 1 : pattern is one of the four legal phases
//   malformed out 1 : a head does not have exactly one lamp on
//   conflict  out 1 : both heads single and neither shows red

module tlm_pattern_decode
   import traffic_light_pkg::*;
(
   input  logic [5:0] lamps,
   output logic [1:0] phase,
   output logic       legal,
   output logic       malformed,
   output logic       conflict
);

   logic   single1;
   logic   single2;
   phase_e ph;

   // Exactly one of three bits: odd parity rules out 0 and 2, the AND rules out 3.
   assign single1   = (^lamps[5:3]) & ~(&lamps[5:3]);
   assign single2   = (^lamps[2:0]) & ~(&lamps[2:0]);
   assign malformed = ~(single1 & single2);
   assign conflict  = single1 & single2 & ~lamps[5] & ~lamps[2];

   // All-red is neither a fault nor one of the four phases; it decodes as not legal.
   always_comb begin
      ph    = PH_G1R2;
      legal = 1'b0;
      if (single1 && single2) begin
         if (lamps[3] && lamps[2]) begin
            ph    = PH_G1R2;
            legal = 1'b1;
         end else if (lamps[4] && lamps[2]) begin
            ph    = PH_Y1R2;
            legal = 1'b1;
         end else if (lamps[5] && lamps[0]) begin
            ph    = PH_R1G2;
            legal = 1'b1;
         end else if (lamps[5] && lamps[1]) begin
            ph    = PH_R1Y2;
            legal = 1'b1;
         end
      end
   end

   assign phase = ph;

endmodule

// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - passive supervisor on the intersection lamp outputs
//
// Purpose: decodes the six lamps into a phase and raises a sticky fault with a
// cause code on malformed/conflicting patterns, illegal phase sequences and
// (when TLM_TIMING_CHECK_EN is defined) out-of-tolerance dwell times.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   red1/yellow1/green1         : head 1 lamps
//   red2/yellow2/green2         : head 2 lamps
//   clr                         : clears fault / fault_code
//   phase, phase_valid          : decoded phase (holds on illegal), current pattern legal
//   synced                      : a legal-to-legal change seen since last illegal pattern/reset
//   fault, fault_code           : sticky fault and first captured cause
//   cycle_cnt                   : entries into G1R2 while synced, wrapping
// Build option: TLM_TIMING_CHECK_EN builds the dwell counter and SHORT/LONG checks.

module traffic_light_monitor
   import traffic_light_pkg::*;
#(
   parameter logic [31:0] GREEN_CYCLES  = 32'd1_500_000_000,
   parameter logic [31:0] YELLOW_CYCLES = 32'd250_000_000,
   parameter logic [31:0] TOL_CYCLES    = 32'd50_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        red1,
   input  logic        yellow1,
   input  logic        green1,
   input  logic        red2,
   input  logic        yellow2,
   input  logic        green2,
   input  logic        clr,
   output logic [1:0]  phase,
   output logic        phase_valid,
   output logic        synced,
   output logic        fault,
   output logic [2:0]  fault_code,
   output logic [15:0] cycle_cnt
);

   lamps_t      cur_q, cur_d, prev_q, prev_d;
   logic        cur_vld_q, cur_vld_d, prev_vld_q, prev_vld_d;
   logic        prev_legal_q, prev_legal_d;
   phase_e      prev_phase_q, prev_phase_d;
   phase_e      phase_q, phase_d;
   logic        phase_valid_q, phase_valid_d;
   logic        synced_q, synced_d;
   logic        fault_q, fault_d;
   logic [2:0]  fault_code_q, fault_code_d;
   logic [15:0] cycle_cnt_q, cycle_cnt_d;

   logic [1:0]  dec_phase;
   phase_e      cur_phase;
   logic        cur_legal, cur_malformed, cur_conflict;
   logic        changed, ll_change, seq_err, short_err, long_err;
   logic        fault_base;
   logic [2:0]  fault_code_base, ev_code;

   tlm_pattern_decode u_decode (
      .lamps     (cur_q),
      .phase     (dec_phase),
      .legal     (cur_legal),
      .malformed (cur_malformed),
      .conflict  (cur_conflict)
   );

   assign cur_phase = phase_e'(dec_phase);

   // cur/prev carry valid bits so the cleared reset pattern is never judged.
   assign changed   = cur_vld_q & prev_vld_q & (cur_q != prev_q);
   assign ll_change = changed & prev_legal_q & cur_legal;
   assign seq_err   = ll_change & (cur_phase != next_phase(prev_phase_q));

   always_comb begin
      cur_d         = {red1, yellow1, green1, red2, yellow2, green2};
      cur_vld_d     = 1'b1;
      prev_d        = cur_q;
      prev_vld_d    = cur_vld_q;
      prev_legal_d  = cur_vld_q & cur_legal;
      prev_phase_d  = cur_phase;
      phase_d       = phase_q;
      phase_valid_d = phase_valid_q;
      synced_d      = synced_q;
      cycle_cnt_d   = cycle_cnt_q;

      if (cur_vld_q) begin
         phase_valid_d = cur_legal;
         if (cur_legal) begin
            phase_d = cur_phase;
         end
         if (!cur_legal) begin
            synced_d = 1'b0;
         end else if (ll_change) begin
            synced_d = 1'b1;
         end
         if (ll_change && !seq_err && cur_phase == PH_G1R2 && synced_q) begin
            cycle_cnt_d = cycle_cnt_q + 16'd1;
         end
      end
   end

   always_comb begin
      ev_code = FC_NONE;
      if (cur_vld_q) begin
         if (cur_conflict) begin
            ev_code = FC_CONFLICT;
         end else if (cur_malformed) begin
            ev_code = FC_MALFORMED;
         end else if (seq_err) begin
            ev_code = FC_SEQUENCE;
         end else if (short_err) begin
            ev_code = FC_SHORT;
         end else if (long_err) begin
            ev_code = FC_LONG;
         end
      end

      // clr clears first, so an event in the same cycle is still captured.
      fault_base      = clr ? 1'b0 : fault_q;
      fault_code_base = clr ? FC_NONE : fault_code_q;
      fault_d         = fault_base;
      fault_code_d    = fault_code_base;
      if (!fault_base && ev_code != FC_NONE) begin
         fault_d      = 1'b1;
         fault_code_d = ev_code;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cur_q         <= '0;
         cur_vld_q     <= 1'b0;
         prev_q        <= '0;
         prev_vld_q    <= 1'b0;
         prev_legal_q  <= 1'b0;
         prev_phase_q  <= PH_G1R2;
         phase_q       <= PH_G1R2;
         phase_valid_q <= 1'b0;
         synced_q      <= 1'b0;
         fault_q       <= 1'b0;
         fault_code_q  <= FC_NONE;
         cycle_cnt_q   <= '0;
      end else begin
         cur_q         <= cur_d;
         cur_vld_q     <= cur_vld_d;
         prev_q        <= prev_d;
         prev_vld_q    <= prev_vld_d;
         prev_legal_q  <= prev_legal_d;
         prev_phase_q  <= prev_phase_d;
         phase_q       <= phase_d;
         phase_valid_q <= phase_valid_d;
         synced_q      <= synced_d;
         fault_q       <= fault_d;
         fault_code_q  <= fault_code_d;
         cycle_cnt_q   <= cycle_cnt_d;
      end
   end

`ifdef TLM_TIMING_CHECK_EN
   // dwell_q is the run length of the pattern now in prev; run_len is the
   // run length including cur. timed_q is the timed flag of the phase in prev.
   logic [31:0] dwell_q, dwell_d, run_len, exp_prev, exp_cur;
   logic        timed_q, timed_d, first, cur_timed;

   always_comb begin
      first = cur_vld_q & ~prev_vld_q;
      if (changed || first) begin
         run_len = 32'd1;
      end else if (&dwell_q) begin
         run_len = dwell_q;
      end else begin
         run_len = dwell_q + 32'd1;
      end
      dwell_d   = cur_vld_q ? run_len : 32'd0;
      cur_timed = cur_vld_q & cur_legal & (changed ? prev_legal_q : timed_q);
      timed_d   = cur_timed;
      exp_prev  = expected_dwell(prev_phase_q, GREEN_CYCLES, YELLOW_CYCLES);
      exp_cur   = expected_dwell(cur_phase, GREEN_CYCLES, YELLOW_CYCLES);
      short_err = changed & timed_q & (dwell_q < exp_prev - TOL_CYCLES);
      // Equality on a monotonic counter fires exactly once per phase.
      long_err  = cur_timed & ~changed & (run_len == exp_cur + TOL_CYCLES + 32'd1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dwell_q <= '0;
         timed_q <= 1'b0;
      end else begin
         dwell_q <= dwell_d;
         timed_q <= timed_d;
      end
   end
`else
   logic unused_timing_params;
   assign unused_timing_params = ^{GREEN_CYCLES, YELLOW_CYCLES, TOL_CYCLES};
   assign short_err = 1'b0;
   assign long_err  = 1'b0;
`endif

   assign phase       = phase_q;
   assign phase_valid = phase_valid_q;
   assign synced      = synced_q;
   assign fault       = fault_q;
   assign fault_code  = fault_code_q;
   assign cycle_cnt   = cycle_cnt_q;

endmodule
